// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                          |
// | Instruction prefetch queue between fetch and decode, with flush.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic [31:0]   out_pc4,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_push;
  logic          w_pop;

  // Handshake flags depend only on the registered occupancy.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  assign out_pc   = mem_q[rp_q][63:32];
  assign out_inst = mem_q[rp_q][31:0];
  assign out_pc4  = out_pc + 32'd4;
  assign count    = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (w_push) wp_d = wp_q + AW'(1);
      if (w_pop)  rp_d = rp_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is only cleared by reset; a flush leaves stale entries behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_push) begin
      mem_q[wp_q] <= {in_pc, in_inst};
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the fetch stage and decode. Captures each fetched `{pc, instruction}` pair under a valid/ready handshake and presents the oldest entry to decode, decoupling fetch from decode stalls. A synchronous flush discards all buffered entries on a control-flow redirect (taken branch, `jal`, or `jalr`) so that wrong-path instructions never reach decode.

## Interface

**Parameters**
- `DEPTH`, default 4: number of entries; must be a power of two and at least 2.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy counter.

**Ports**
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous; discards all entries at the next edge.
- `in_valid` in 1: fetch presents a valid pair this cycle.
- `in_pc` in 32: PC of the fetched instruction.
- `in_inst` in 32: instruction word read at `in_pc`.
- `in_ready` out 1: the queue can accept an entry.
- `out_valid` out 1: the head entry is valid.
- `out_pc` out 32: PC of the head entry.
- `out_inst` out 32: instruction of the head entry.
- `out_pc4` out 32: `out_pc + 4`, modulo 2^32.
- `out_ready` in 1: decode consumes the head entry this cycle.
- `count` out CW: current occupancy, 0..DEPTH.

## Operation
- **Storage:** DEPTH × 64-bit register array holding `{pc, inst}`, plus write pointer `wp`, read pointer `rp` (each log2(DEPTH) bits, wrapping modulo DEPTH) and counter `count`.
- **Push:** occurs when `in_valid && in_ready && !flush`. Write `{in_pc, in_inst}` at `wp`, then increment `wp`.
- **Pop:** occurs when `out_valid && out_ready && !flush`. Increment `rp`.
- **Counter update:**
  - Push only: `count + 1`.
  - Pop only: `count - 1`.
  - Both push and pop: `count` unchanged; pointers advance independently.
- **Ready/valid:**
  - `in_ready = (count != DEPTH)`. When full, a push is refused even if a pop occurs in the same cycle; there is no full-bypass.
  - `out_valid = (count != 0)`. There is no empty-bypass; a pushed entry becomes visible at the edge after the push.
- **Head outputs:** `out_pc`, `out_inst` and `out_pc4` are combinational reads of the entry at `rp`. When `out_valid = 0`, their values are don't-care for decode; the bench checks them only when valid.
- **Flush:**
  - At the next edge: `wp = rp = 0` and `count = 0`.
  - Any push or pop presented in the flush cycle is discarded.
  - Storage contents are not cleared.
  - `flush` takes priority over all other inputs.
- **Wrap-around:** pointers roll over from DEPTH−1 to 0 with no special handling. `out_pc4` wraps from 0xFFFFFFFC to 0x00000000.

## Timing
- **Reset (asynchronous, immediate on assertion):**
  - `wp = rp = 0`, `count = 0`, all storage cleared to 0.
  - Hence `in_ready = 1`, `out_valid = 0`, `out_pc = 0`, `out_inst = 0`, `out_pc4 = 4`.
- **Reset mid-operation:** all buffered entries are lost. The first push after `reset` deasserts lands at entry 0.
- **Latency:** push at edge N makes the entry visible at the head after edge N (cycle N+1) if the queue was empty, otherwise behind the older entries.
- **Throughput:** with DEPTH ≥ 2 and no stalls, sustained rate is one push and one pop per cycle.
- **Stall stability:** while `out_valid && !out_ready && !flush`, the head outputs remain stable cycle to cycle.
- **Registered signals:** `count` is a register. `in_ready` and `out_valid` are derived only from `count`, with no combinational path from `in_valid` or `out_ready`.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-cycle. Expect immediately: `count = 0`, `in_ready = 1`, `out_valid = 0`, `out_pc4 = 0x4`.
- **Fill to full:** with `out_ready = 0`, push PCs 0x0, 0x4, 0x8, 0xC (DEPTH=4).
  - Expect `count = 4` and `in_ready = 0`.
  - A fifth push of 0x10 is refused.
  - Then raise `out_ready`: decode receives 0x0, 0x4, 0x8, 0xC in order with the correct `out_inst`.
- **Simultaneous push and pop:** at `count = 2`, push 0x20 while popping.
  - Expect `count` to stay 2 and the head to advance to the next older entry.
  - After draining, 0x20 appears last.
- **Flush:** at `count = 3`, assert `flush` together with `in_valid` (pc 0x40).
  - Next cycle: `count = 0`, `out_valid = 0`.
  - 0x40 is never delivered.
  - A subsequent push of 0x100 is visible at the head one cycle later.
- **Pointer wrap:** push and pop 10 entries continuously with 1-cycle overlap. Expect in-order delivery across the `wp`/`rp` roll-over from 3 to 0 and `count` never exceeding 4.
- **PC wrap:** push pc 0xFFFFFFFC with inst 0x00000013. Expect `out_pc4 = 0x00000000`.
